fiapp_seq: RTL and testbench
============================

# fiapp_seq

Stimulus sequencer and checker for the fiapp capture pipeline. It serialises a programmed bit pattern onto the pipeline's `a` input and issues one `enable` pulse per bit, with a configurable idle gap between bits. It then checks the pipeline's `o2`/`o3` outputs against the expected value two cycles after each enable. It sits between the SysObs test/observability control logic and a fiapp instance, and owns that instance's `a` and `enable` inputs.

## Interface
- `W`, 16: pattern register width, maximum bits per run.
- `GAP`, 0: idle cycles inserted between consecutive enable pulses (≥0).
- `CNT_W`, 8: mismatch counter width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request, sampled only in IDLE.
- `pattern`  in  W  bits to drive, LSB first; captured on accepted start.
- `len`  in  $clog2(W+1)  number of bits; captured on accepted start; values >W clamp to W.
- `o2`  in  1  pipeline delayed-capture output.
- `o3`  in  1  pipeline inverted delayed-capture output.
- `a`  out  1  data to pipeline.
- `enable`  out  1  capture enable to pipeline.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `err`  out  1  sticky mismatch flag for current/last run.
- `err_count`  out  CNT_W  saturating per-bit mismatch count.

## Operation
- States: IDLE, DRIVE, GAP, DRAIN1, DRAIN2, DONE.
- IDLE:
  - `start`=1 captures `pattern` and the clamped `len`, and clears `err` and `err_count`.
  - len≠0 → DRIVE.
  - len=0 → DONE.
- DRIVE:
  - Drives `a` = current bit and `enable`=1 for exactly one cycle.
  - Pushes the expected bit into a 2-stage check pipe.
  - If more bits remain: → GAP when GAP>0, else → DRIVE with the next bit.
  - Last bit → DRAIN1.
- GAP: `enable`=0 and `a` holds its last value for GAP cycles, then → DRIVE.
- DRAIN1 → DRAIN2 → DONE. These two states flush the check pipe.
- DONE: `done`=1 for one cycle, `busy`=0, → IDLE. A start can be accepted in the next cycle.
- Checker:
  - A check entry pushed in cycle k is evaluated in cycle k+2.
  - Mismatch when `o2`≠exp or `o3`≠!exp.
  - A mismatch sets `err` and increments `err_count` by 1, regardless of whether one or both outputs are wrong.
  - `err_count` saturates at 2^CNT_W−1.
- `start` while not in IDLE is ignored; pattern and len are not re-captured.
- `busy`=1 in DRIVE, GAP, DRAIN1 and DRAIN2.

## Timing
- Reset (async, `reset_n`=0): state IDLE; `a`=0, `enable`=0, `busy`=0, `done`=0, `err`=0, `err_count`=0; check pipe cleared.
- Reset mid-run forces outputs to these values immediately, without waiting for a clock edge. The run is abandoned and no `done` is issued.
- Let start be accepted at the edge ending cycle 0:
  - Bit i is driven in cycle 1+i·(GAP+1).
  - The last drive cycle is L = 1+(len−1)(GAP+1).
  - The last check is evaluated in cycle L+2.
  - `done` pulses in cycle L+3, with `err`/`err_count` already reflecting every check.
- len=0: `done` in cycle 1; `busy` and `enable` stay 0.
- `err` and `err_count` hold their values after DONE until the next accepted start.
- Pipeline assumption: fiapp captures `a` on the edge ending the enable cycle, and its reset is released before the start is accepted.

## Configuration
- `FIAPP_SEQ_CHECK_EN` defined:
  - Checker and check pipe are compiled in.
  - `err` and `err_count` behave as specified above.
- `FIAPP_SEQ_CHECK_EN` undefined:
  - Checker logic is removed.
  - `err`=0 and `err_count`=0 constantly.
  - `o2` and `o3` are unused.
  - State sequence and all cycle timing, including the DRAIN states and the `done` cycle, are unchanged.

## Test plan
- W=16, GAP=0, pattern=0x00A5, len=8, healthy pipeline → `a`=1,0,1,0,0,1,0,1 in cycles 1–8; `enable`=1 in cycles 1–8; `done` in cycle 11; `err`=0, `err_count`=0.
- GAP=2, pattern=3'b110, len=3 → `enable` high only in cycles 1, 4, 7 with `a`=0,1,1; `done` in cycle 10.
- Fault: `o2` forced 0, pattern=0xF, len=4 → `err`=1 and `err_count`=4 at `done`. With the macro undefined → `err`=0 and `err_count`=0.
- len=0 → `done` in cycle 1; `busy` and `enable` never asserted. len=20 with W=16 → 16 enable pulses.
- `start` pulsed again in cycle 3 of a len=8 run → ignored, single `done` in cycle 11. Separately, `reset_n` low in cycle 4 → `enable`=0 and `busy`=0 asynchronously, no `done`; a new start after release completes normally.
- CNT_W=2, `o3` forced equal to `o2`, len=8 → `err_count` saturates at 3, `err`=1.

Source files
------------

// File: rtl/fiapp_seq.sv
// fiapp_seq: serialises a bit pattern onto a fiapp pipeline and checks its o2/o3 response.
// Define FIAPP_SEQ_CHECK_EN to build the response checker; without it err/err_count stay 0.
module fiapp_seq #(
  parameter int W     = 16,
  parameter int GAP   = 0,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [W-1:0]           pattern,
  input  logic [$clog2(W+1)-1:0] len,
  input  logic                   o2,
  input  logic                   o3,
  output logic                   a,
  output logic                   enable,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [CNT_W-1:0]       err_count
);

  localparam int LW = $clog2(W + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [LW-1:0] W_LEN    = LW'(W);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP,
    S_DRAIN1,
    S_DRAIN2,
    S_DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    pat_q;
  logic [LW-1:0]   rem;
  logic [GW-1:0]   gap_cnt;
  logic [LW-1:0]   len_clamped;

  assign len_clamped = (len > W_LEN) ? W_LEN : len;

  // pat_q is a right-shifting copy of the pattern; rem counts bits still to drive after the current one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      pat_q   <= '0;
      rem     <= '0;
      gap_cnt <= '0;
      a       <= 1'b0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      enable <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len_clamped != '0) begin
              state  <= S_DRIVE;
              a      <= pattern[0];
              pat_q  <= pattern >> 1;
              rem    <= len_clamped - 1'b1;
              enable <= 1'b1;
              busy   <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DRIVE: begin
          if (rem == '0) begin
            state <= S_DRAIN1;
          end else if (GAP > 0) begin
            state   <= S_GAP;
            gap_cnt <= GAP_LAST;
          end else begin
            a      <= pat_q[0];
            pat_q  <= pat_q >> 1;
            rem    <= rem - 1'b1;
            enable <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state  <= S_DRIVE;
            a      <= pat_q[0];
            pat_q  <= pat_q >> 1;
            rem    <= rem - 1'b1;
            enable <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_DRAIN1: state <= S_DRAIN2;
        S_DRAIN2: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FIAPP_SEQ_CHECK_EN
  logic [1:0] chk_vld;
  logic [1:0] chk_exp;
  logic       mismatch;

  assign mismatch = chk_vld[1] && ((o2 != chk_exp[1]) || (o3 == chk_exp[1]));

  // Each driven bit reaches the pipeline outputs two cycles later; stage 1 lines up with that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_vld   <= '0;
      chk_exp   <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      chk_vld <= {chk_vld[0], enable};
      chk_exp <= {chk_exp[0], a};
      if (state == S_IDLE && start) begin
        err       <= 1'b0;
        err_count <= '0;
      end else if (mismatch) begin
        err <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end
`else
  logic unused_pipe_outputs;
  assign unused_pipe_outputs = o2 ^ o3;
  assign err       = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_fiapp_seq.sv
// tb_fiapp_seq: drives fiapp_seq against a behavioural fiapp model and a cycle-schedule reference.
// Honours FIAPP_SEQ_CHECK_EN when deciding whether err/err_count are expected to move.
module tb_fiapp_seq;
  localparam int W     = 16;
  localparam int GAP   = 2;
  localparam int CNT_W = 3;
  localparam int LW    = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     pattern = '0;
  logic [LW-1:0]    len = '0;
  logic             o2, o3, a, enable, busy, done, err;
  logic [CNT_W-1:0] err_count;

  int vectors     = 0;
  int miscompares = 0;
  int fault_mode  = 0;
  logic q1, q2;

  fiapp_seq #(.W(W), .GAP(GAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pattern(pattern), .len(len),
    .o2(o2), .o3(o3), .a(a), .enable(enable), .busy(busy), .done(done),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Minimal fiapp: capture a on enable, one more delay stage, plus selectable output faults.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      if (enable) q1 <= a;
      q2 <= q1;
    end
  end
  assign o2 = (fault_mode == 1) ? 1'b0 : q2;
  assign o3 = (fault_mode == 2) ? o2 : ~q2;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int effLen(input int ln);
    return (ln > W) ? W : ln;
  endfunction

  function automatic int expErrCount(input logic [W-1:0] pat, input int ln, input int fault);
    int n = 0;
`ifdef FIAPP_SEQ_CHECK_EN
    for (int i = 0; i < effLen(ln); i++) begin
      logic b, o2v, o3v;
      b   = pat[i];
      o2v = (fault == 1) ? 1'b0 : b;
      o3v = (fault == 2) ? o2v : !b;
      if (o2v != b || o3v != !b) n++;
    end
    if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
`endif
    return n;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] pat, input int ln, input int fault, input int restart_cyc);
    int eff, last, done_cyc, exp_cnt;
    logic exp_en, exp_busy;
    eff      = effLen(ln);
    last     = 1 + (eff - 1) * (GAP + 1);
    done_cyc = (eff == 0) ? 1 : last + 3;
    exp_cnt  = expErrCount(pat, ln, fault);
    @(negedge clk);
    fault_mode = fault;
    pattern    = pat;
    len        = LW'(ln);
    start      = 1'b1;
    for (int c = 1; c <= done_cyc + 2; c++) begin
      @(posedge clk);
      #1;
      start = (c == restart_cyc);
      if (c == restart_cyc) begin
        pattern = ~pat;
        len     = LW'(W);
      end
      exp_en   = (eff > 0) && (c <= last) && ((c - 1) % (GAP + 1) == 0);
      exp_busy = (eff > 0) && (c <= last + 2);
      checkOutput("enable", 32'(enable), 32'(exp_en));
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("done", 32'(done), 32'(c == done_cyc));
      if (eff > 0 && c <= last)
        checkOutput("a", 32'(a), 32'(pat[(c - 1) / (GAP + 1)]));
      if (c == done_cyc || c == done_cyc + 2) begin
        checkOutput("err", 32'(err), 32'(exp_cnt != 0));
        checkOutput("err_count", 32'(err_count), 32'(exp_cnt));
      end
    end
    start = 1'b0;
  endtask

  task automatic resetMidRun();
    @(negedge clk);
    fault_mode = 2;
    pattern    = 16'h00FF;
    len        = LW'(8);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("enable_pre_rst", 32'(enable), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_enable", 32'(enable), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_a", 32'(a), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    repeat (2) @(negedge clk);
    reset_n    = 1'b1;
    fault_mode = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      checkOutput("post_rst_done", 32'(done), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #12;
    checkOutput("reset_a", 32'(a), 32'd0);
    checkOutput("reset_enable", 32'(enable), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_err_count", 32'(err_count), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(16'h00A5, 8, 0, 0);
    applyStimulus(16'h0006, 3, 0, 0);
    applyStimulus(16'h000F, 4, 1, 0);
    applyStimulus(16'h1234, 0, 0, 0);
    applyStimulus(16'hBEEF, 20, 0, 0);
    applyStimulus(16'h5A3C, 8, 0, 3);
    applyStimulus(16'hFFFF, 8, 2, 0);
    resetMidRun();
    applyStimulus(16'h00C3, 8, 0, 0);

    for (int r = 0; r < 20; r++)
      applyStimulus(W'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 2)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
